cfu_tpu_ctrl: RTL
=================

CFU_TPU_CTRL -- requirements
Module: cfu_tpu_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 8: global-buffer index width.
REQ-002 Parameter LANES, default 4: 32-bit lanes per C word; C width = 32*LANES, LANES in 1..16.
REQ-003 Parameter DIM_BITS, default 32: width of K/M/N registers.
REQ-004 clk  in  1  single clock; all logic posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid in 1, cmd_ready out 1: CFU command handshake.
REQ-007 cmd_payload_function_id  in  10  opcode = bits [9:3].
REQ-008 cmd_payload_inputs_0, cmd_payload_inputs_1  in  32 each  operands.
REQ-009 rsp_valid out 1, rsp_ready in 1, rsp_payload_outputs_0 out 32: response handshake.
REQ-010 a_wr_en/b_wr_en out 1, a_index/b_index out ADDR_BITS, a_data_in/b_data_in out 32, a_data_out/b_data_out in 32: host ports of A/B buffers.
REQ-011 c_index out ADDR_BITS, c_data_out in 32*LANES: host read port of C buffer.
REQ-012 tpu_rst_n out 1, tpu_in_valid out 1, tpu_busy in 1, K/M/N out DIM_BITS: TPU control.

Function
REQ-013 FSM states IDLE, EXEC, RDWAIT, RESP; cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid&&cmd_ready.
REQ-014 Accept latches opcode and operands; IDLE->EXEC; EXEC->RDWAIT for buffer reads, else ->RESP.
REQ-015 RDWAIT lasts exactly one cycle (1-cycle synchronous buffer read), then ->RESP capturing read data.
REQ-016 RESP: rsp_valid=1, payload stable until rsp_valid&&rsp_ready; then ->IDLE; cmd_valid ignored while not IDLE.
REQ-017 Opcodes: 1 tpu_rst_n<=in0[0], K/M/N<=0; 2/4/6 set K/M/N<=in0; 3/5/7 read K/M/N; 8 write A[in0]<=in1; 9 read A[in0]; 10 write B[in0]<=in1; 11 read B[in0]; 12 start; 13 read {31'b0,tpu_busy}; 14 read C[in0] lane in1.
REQ-018 Write ops: a_wr_en/b_wr_en SHALL pulse exactly one cycle in EXEC; response payload 0.
REQ-019 Opcode 14: lane = in1 mod LANES; payload = c_data_out[32*lane+:32].
REQ-020 Opcode 12: tpu_in_valid pulses one cycle in EXEC; ignored (payload 1, no pulse) if tpu_busy=1; else payload 0.
REQ-021 While tpu_busy=1, opcodes 8/10 SHALL be dropped (no write) with payload 0xFFFFFFFF; reads still serviced.
REQ-022 Unknown opcode: no side effect, payload 0.
REQ-023 Addresses truncate to ADDR_BITS; index outputs held between commands.
REQ-024 Command-to-rsp_valid latency: 2 cycles non-read, 3 cycles buffer read.

Reset
REQ-025 rst_n low: state IDLE, cmd_ready=1 after release, rsp_valid=0, payload=0, all wr_en=0, tpu_in_valid=0, tpu_rst_n=1, K=M=N=0, indices 0, pointers 0.
REQ-026 Reset mid-command or mid-response SHALL abort it; no response later emitted.

Configuration
REQ-027 Macro CFU_TPU_AUTOINC_EN defined: opcode 18 sets a_ptr=b_ptr=in0; 19 writes A[a_ptr]<=in0, a_ptr+1; 20 writes B[b_ptr]<=in0, b_ptr+1; pointers wrap 2^ADDR_BITS-1->0; busy-drop per REQ-021, pointer unchanged.
REQ-028 Macro undefined: opcodes 18-20 behave as unknown; no pointer registers synthesised.

Structure
REQ-029 Shared package cfu_tpu_pkg: opcode constants, FSM state encoding, BUSY_REJECT=32'hFFFFFFFF.
REQ-030 One sub-module cfu_lane_mux (parametrised by LANES) selects the C lane; all else in top.

Verification
REQ-031 Reset, opcode 2 in0=5 then opcode 3 -> response 5; cmd_ready low until response consumed.
REQ-032 Opcode 8 in0=3 in1=0xDEADBEEF, then opcode 9 in0=3 -> a_wr_en one cycle, read returns 0xDEADBEEF, rsp_valid 3 cycles after accept.
REQ-033 c_data_out lane2=0x12345678 (LANES=4), opcode 14 in1=6 -> payload 0x12345678.
REQ-034 tpu_busy=1, opcode 10 -> no b_wr_en, payload 0xFFFFFFFF; opcode 12 -> no tpu_in_valid, payload 1.
REQ-035 rsp_ready low 10 cycles -> rsp_valid and payload held, then single handshake, back to IDLE.
REQ-036 AUTOINC on, ADDR_BITS=2: opcode 18 in0=3, two opcode 19 -> writes A[3], A[0]; AUTOINC off -> payload 0, no write.

Source files
------------

// File: rtl/cfu_tpu_pkg.sv
// Shared definitions for the CFU-to-TPU control block:
// opcode constants, FSM state encoding and the busy-reject code.
package cfu_tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [6:0] OP_TPU_RST = 7'd1;
  localparam logic [6:0] OP_SET_K   = 7'd2;
  localparam logic [6:0] OP_GET_K   = 7'd3;
  localparam logic [6:0] OP_SET_M   = 7'd4;
  localparam logic [6:0] OP_GET_M   = 7'd5;
  localparam logic [6:0] OP_SET_N   = 7'd6;
  localparam logic [6:0] OP_GET_N   = 7'd7;
  localparam logic [6:0] OP_WR_A    = 7'd8;
  localparam logic [6:0] OP_RD_A    = 7'd9;
  localparam logic [6:0] OP_WR_B    = 7'd10;
  localparam logic [6:0] OP_RD_B    = 7'd11;
  localparam logic [6:0] OP_START   = 7'd12;
  localparam logic [6:0] OP_BUSY    = 7'd13;
  localparam logic [6:0] OP_RD_C    = 7'd14;
  localparam logic [6:0] OP_SET_PTR = 7'd18;
  localparam logic [6:0] OP_AUTO_A  = 7'd19;
  localparam logic [6:0] OP_AUTO_B  = 7'd20;

  localparam logic [31:0] BUSY_REJECT = 32'hFFFF_FFFF;

  // Buffer reads need the extra RDWAIT cycle for the synchronous RAM.
  function automatic logic isBufRead(input logic [6:0] op);
    return (op == OP_RD_A) || (op == OP_RD_B) || (op == OP_RD_C);
  endfunction

endpackage

// File: rtl/cfu_lane_mux.sv
// Selects one 32-bit lane out of a wide C-buffer word; the lane
// number wraps modulo LANES.
module cfu_lane_mux #(
  parameter int LANES = 4
) (
  input  logic [32*LANES-1:0] data_i,
  input  logic [31:0]         sel_i,
  output logic [31:0]         lane_o
);

  logic [31:0] laneIdx;

  assign laneIdx = sel_i % 32'(LANES);

  always_comb begin
    lane_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (laneIdx == 32'(i)) lane_o = data_i[32*i +: 32];
    end
  end

endmodule

// File: rtl/cfu_tpu_ctrl.sv
// CFU command decoder driving the TPU global buffers and control registers.
// Define CFU_TPU_AUTOINC_EN to add pointer-based streaming writes (opcodes 18-20).
module cfu_tpu_ctrl
  import cfu_tpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LANES     = 4,
  parameter int DIM_BITS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [9:0]             cmd_payload_function_id,
  input  logic [31:0]            cmd_payload_inputs_0,
  input  logic [31:0]            cmd_payload_inputs_1,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_payload_outputs_0,
  output logic                   a_wr_en,
  output logic [ADDR_BITS-1:0]   a_index,
  output logic [31:0]            a_data_in,
  input  logic [31:0]            a_data_out,
  output logic                   b_wr_en,
  output logic [ADDR_BITS-1:0]   b_index,
  output logic [31:0]            b_data_in,
  input  logic [31:0]            b_data_out,
  output logic [ADDR_BITS-1:0]   c_index,
  input  logic [32*LANES-1:0]    c_data_out,
  output logic                   tpu_rst_n,
  output logic                   tpu_in_valid,
  input  logic                   tpu_busy,
  output logic [DIM_BITS-1:0]    K,
  output logic [DIM_BITS-1:0]    M,
  output logic [DIM_BITS-1:0]    N
);

  state_e                state_q, state_d;
  logic [6:0]            op_q;
  logic [31:0]           in0_q, in1_q;
  logic [31:0]           rspData_q;
  logic [ADDR_BITS-1:0]  aIndex_q, bIndex_q, cIndex_q;
  logic [31:0]           aData_q, bData_q;
  logic                  tpuRstN_q;
  logic [DIM_BITS-1:0]   k_q, m_q, n_q;
`ifdef CFU_TPU_AUTOINC_EN
  logic [ADDR_BITS-1:0]  aPtr_q, bPtr_q;
`endif

  logic [6:0]            cmdOp;
  logic [ADDR_BITS-1:0]  cmdAddr;
  logic [2:0]            unusedFunctBits;
  logic [31:0]           laneData;
  logic [31:0]           readData;
  logic [31:0]           execData;

  assign cmdOp           = cmd_payload_function_id[9:3];
  assign unusedFunctBits = cmd_payload_function_id[2:0];
  assign cmdAddr         = cmd_payload_inputs_0[ADDR_BITS-1:0];

  cfu_lane_mux #(.LANES(LANES)) uLaneMux (
    .data_i (c_data_out),
    .sel_i  (in1_q),
    .lane_o (laneData)
  );

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    a_wr_en      = 1'b0;
    b_wr_en      = 1'b0;
    tpu_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: begin
        state_d = isBufRead(op_q) ? RDWAIT : RESP;
        // Side-effect strobes are suppressed while the TPU is running.
        if (!tpu_busy) begin
          case (op_q)
            OP_WR_A:   a_wr_en      = 1'b1;
            OP_WR_B:   b_wr_en      = 1'b1;
            OP_START:  tpu_in_valid = 1'b1;
`ifdef CFU_TPU_AUTOINC_EN
            OP_AUTO_A: a_wr_en      = 1'b1;
            OP_AUTO_B: b_wr_en      = 1'b1;
`endif
            default: ;
          endcase
        end
      end
      RDWAIT: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    execData = '0;
    case (op_q)
      OP_GET_K: execData = 32'(k_q);
      OP_GET_M: execData = 32'(m_q);
      OP_GET_N: execData = 32'(n_q);
      OP_WR_A,
      OP_WR_B:  execData = tpu_busy ? BUSY_REJECT : 32'd0;
      OP_START: execData = tpu_busy ? 32'd1 : 32'd0;
      OP_BUSY:  execData = {31'b0, tpu_busy};
`ifdef CFU_TPU_AUTOINC_EN
      OP_AUTO_A,
      OP_AUTO_B: execData = tpu_busy ? BUSY_REJECT : 32'd0;
`endif
      default: execData = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_RD_A: readData = a_data_out;
      OP_RD_B: readData = b_data_out;
      default: readData = laneData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      in0_q     <= '0;
      in1_q     <= '0;
      rspData_q <= '0;
      aIndex_q  <= '0;
      bIndex_q  <= '0;
      cIndex_q  <= '0;
      aData_q   <= '0;
      bData_q   <= '0;
      tpuRstN_q <= 1'b1;
      k_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
`ifdef CFU_TPU_AUTOINC_EN
      aPtr_q    <= '0;
      bPtr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmdOp;
            in0_q <= cmd_payload_inputs_0;
            in1_q <= cmd_payload_inputs_1;
            // Indices are loaded at accept so the RAMs see them throughout EXEC.
            case (cmdOp)
              OP_WR_A: begin
                aIndex_q <= cmdAddr;
                aData_q  <= cmd_payload_inputs_1;
              end
              OP_RD_A: aIndex_q <= cmdAddr;
              OP_WR_B: begin
                bIndex_q <= cmdAddr;
                bData_q  <= cmd_payload_inputs_1;
              end
              OP_RD_B: bIndex_q <= cmdAddr;
              OP_RD_C: cIndex_q <= cmdAddr;
`ifdef CFU_TPU_AUTOINC_EN
              OP_AUTO_A: begin
                aIndex_q <= aPtr_q;
                aData_q  <= cmd_payload_inputs_0;
              end
              OP_AUTO_B: begin
                bIndex_q <= bPtr_q;
                bData_q  <= cmd_payload_inputs_0;
              end
`endif
              default: ;
            endcase
          end
        end
        EXEC: begin
          rspData_q <= execData;
          case (op_q)
            OP_TPU_RST: begin
              tpuRstN_q <= in0_q[0];
              k_q       <= '0;
              m_q       <= '0;
              n_q       <= '0;
            end
            OP_SET_K: k_q <= DIM_BITS'(in0_q);
            OP_SET_M: m_q <= DIM_BITS'(in0_q);
            OP_SET_N: n_q <= DIM_BITS'(in0_q);
`ifdef CFU_TPU_AUTOINC_EN
            OP_SET_PTR: begin
              aPtr_q <= in0_q[ADDR_BITS-1:0];
              bPtr_q <= in0_q[ADDR_BITS-1:0];
            end
            OP_AUTO_A: if (!tpu_busy) aPtr_q <= aPtr_q + 1'b1;
            OP_AUTO_B: if (!tpu_busy) bPtr_q <= bPtr_q + 1'b1;
`endif
            default: ;
          endcase
        end
        RDWAIT: rspData_q <= readData;
        default: ;
      endcase
    end
  end

  assign rsp_payload_outputs_0 = rspData_q;
  assign a_index   = aIndex_q;
  assign b_index   = bIndex_q;
  assign c_index   = cIndex_q;
  assign a_data_in = aData_q;
  assign b_data_in = bData_q;
  assign tpu_rst_n = tpuRstN_q;
  assign K = k_q;
  assign M = m_q;
  assign N = n_q;

endmodule
